// File: rtl/esp_uart_rx_ctrl.sv
// rtl/esp_uart_rx_ctrl.sv - UART receive FIFO with sticky line status and RTS-style flow control
//
// Buffers bytes from the UART receiver in a first-word-fall-through FIFO,
// records overrun / framing-error / break events as sticky flags and throttles
// the sender through rx_ready with high/low water-mark hysteresis.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   rx_data/rx_valid  byte and one-cycle strobe from the receiver
//   rx_framing_error  framing-error level from the receiver
//   rx_break          break level from the receiver
//   rd_data/rd_valid  FIFO head byte and not-empty indication
//   rd_ack            pop the head (ignored when empty)
//   flush             empty the FIFO at the next edge
//   status_clr        clear all sticky flags at the next edge
//   fifo_count        current occupancy
//   overrun, framing_err, break_det   sticky status
//   break_pulse       one-cycle pulse per break onset
//   rx_ready          flow control to the sender, 1 = may send
module esp_uart_rx_ctrl #(
  parameter int DEPTH_LOG2     = 4,
  parameter int HIGH_WATER     = 12,
  parameter int LOW_WATER      = 4,
  parameter int FLUSH_ON_BREAK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_framing_error,
  input  logic                  rx_break,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ack,
  input  logic                  flush,
  input  logic                  status_clr,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overrun,
  output logic                  framing_err,
  output logic                  break_det,
  output logic                  break_pulse,
  output logic                  rx_ready
);

  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HW_C    = CW'(HIGH_WATER);
  localparam logic [CW-1:0] LW_C    = CW'(LOW_WATER);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  overrun_q, overrun_d;
  logic                  framing_q, framing_d;
  logic                  break_det_q, break_det_d;
  logic                  break_pulse_q;
  logic                  fe_dly_q, brk_dly_q;

  logic fe_rise, brk_rise, do_flush, pop, push, drop;

  assign fe_rise  = rx_framing_error & ~fe_dly_q;
  assign brk_rise = rx_break & ~brk_dly_q;
  // A break onset empties the FIFO with the same precedence as the flush strobe.
  assign do_flush = flush | ((FLUSH_ON_BREAK != 0) & brk_rise);
  assign pop      = rd_ack & (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = rx_valid & ((count_q != DEPTH_C) | pop);
  // Bytes arriving during a flush are discarded silently, not counted as overrun.
  assign drop     = rx_valid & ~push & ~do_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Hysteresis on the post-update occupancy; between the marks the last value holds.
  always_comb begin
    rx_ready_d = rx_ready_q;
    if (count_d >= HW_C)      rx_ready_d = 1'b0;
    else if (count_d <= LW_C) rx_ready_d = 1'b1;
  end

  // Set wins over a same-cycle clear.
  always_comb begin
    overrun_d   = drop     | (overrun_q   & ~status_clr);
    framing_d   = fe_rise  | (framing_q   & ~status_clr);
    break_det_d = brk_rise | (break_det_q & ~status_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rx_ready_q    <= 1'b1;
      overrun_q     <= 1'b0;
      framing_q     <= 1'b0;
      break_det_q   <= 1'b0;
      break_pulse_q <= 1'b0;
      fe_dly_q      <= 1'b0;
      brk_dly_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rx_ready_q    <= rx_ready_d;
      overrun_q     <= overrun_d;
      framing_q     <= framing_d;
      break_det_q   <= break_det_d;
      break_pulse_q <= brk_rise;
      fe_dly_q      <= rx_framing_error;
      brk_dly_q     <= rx_break;
    end
  end

  // Storage carries no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push && !do_flush) mem[wr_ptr_q] <= rx_data;
  end

  assign rd_valid    = (count_q != '0);
  assign rd_data     = rd_valid ? mem[rd_ptr_q] : 8'h00;
  assign fifo_count  = count_q;
  assign overrun     = overrun_q;
  assign framing_err = framing_q;
  assign break_det   = break_det_q;
  assign break_pulse = break_pulse_q;
  assign rx_ready    = rx_ready_q;

endmodule

// File: doc/esp_uart_rx_ctrl.md
Name: esp_uart_rx_ctrl

Overview:
Receive-side controller between the ESP UART byte receiver and the CPU/register-bus side. It buffers received bytes in a FIFO with first-word-fall-through reads and sequences consumer pops. It also tracks overrun, framing-error and break events as sticky status, and drives an RTS-style flow-control output with hysteresis so the ESP can be throttled before the FIFO overflows.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 entries (16)
HIGH_WATER, 12, count at or above which rx_ready deasserts
LOW_WATER, 4, count at or below which rx_ready reasserts; must be < HIGH_WATER
FLUSH_ON_BREAK, 1, 1 = a detected break empties the FIFO

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
rx_data  input  8  byte from UART receiver
rx_valid  input  1  one-cycle strobe, rx_data valid
rx_framing_error  input  1  level from receiver, framing error on current frame
rx_break  input  1  level from receiver, break condition on line
rd_data  output  8  FIFO head byte, valid when rd_valid=1
rd_valid  output  1  FIFO not empty
rd_ack  input  1  pop head, honoured only when rd_valid=1
flush  input  1  one-cycle strobe, empty FIFO
status_clr  input  1  one-cycle strobe, clear all sticky flags
fifo_count  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
overrun  output  1  sticky, byte dropped because FIFO full
framing_err  output  1  sticky, framing error seen
break_det  output  1  sticky, break seen
break_pulse  output  1  one-cycle pulse on each break onset
rx_ready  output  1  flow control to ESP, 1 = may send

Behaviour:
- Reset state: FIFO empty; fifo_count=0, rd_valid=0, rd_data=0.
- Reset state, flags: overrun, framing_err, break_det and break_pulse are 0. rx_ready=1. Edge-detect registers for rx_framing_error and rx_break are cleared to 0.
- Reset asserted mid-operation drops all buffered data immediately, without waiting for a clock edge.
- Storage: memory array 2^DEPTH_LOG2 x 8, write pointer and read pointer of DEPTH_LOG2 bits each. Pointers wrap modulo depth. The occupancy counter is separate (DEPTH_LOG2+1 bits), so full and empty are unambiguous.
- Push: when rx_valid=1 and (count < depth, or a pop occurs in the same cycle), write rx_data at the write pointer and increment the write pointer.
- Overflow: rx_valid=1 with count = depth and no pop in the same cycle drops the byte. The FIFO is unchanged and overrun is set.
- Pop: when rd_ack=1 and count > 0, increment the read pointer. rd_ack while empty is ignored; count stays 0 and no flag is set.
- Simultaneous push and pop: count unchanged. This holds when full (no overrun) and when count=1. When empty, only the push takes effect (count becomes 1).
- FWFT: rd_data = mem[read pointer], registered storage. A byte pushed at edge N shows on rd_data and rd_valid=1 after edge N (zero extra latency). After a pop at edge N, the next head is presented after edge N.
- Flush: when flush=1, both pointers and count go to 0 at the next edge. Flush overrides any push or pop in the same cycle; a byte arriving in that cycle is discarded and overrun is not set.
- Event detection: rising edges of rx_framing_error and rx_break, using 1-cycle-delayed copies.
  - framing_err is set on a framing-error rising edge.
  - On a break rising edge: break_det is set and break_pulse=1 for exactly one cycle.
  - If FLUSH_ON_BREAK=1, that same edge also flushes the FIFO, with the same precedence as the flush input.
  - Levels held high produce no further events.
- Sticky clear: status_clr=1 clears overrun, framing_err and break_det at the next edge. If a set event occurs in the same cycle, set wins.
- Flow control, evaluated on the next-state count each edge:
  - next count >= HIGH_WATER: rx_ready <= 0.
  - next count <= LOW_WATER: rx_ready <= 1.
  - Otherwise rx_ready holds.
  - rx_ready is a registered output.
- fifo_count is a registered output, equal to the current occupancy.
- Push and overrun use only rx_valid. Error levels never gate pushes; the receiver already suppresses rx_valid for bad frames.

Test Plan:
- Push 0x11,0x22,0x33 (one rx_valid each, no rd_ack) -> fifo_count=3, rd_data=0x11. Pop three times -> rd_data 0x22, then 0x33, then rd_valid=0 and count=0. A fourth rd_ack leaves count=0 with no flags set.
- Push 16 bytes 0x00..0x0F, then push 0xAA -> count=16, overrun=1, 0xAA absent. Drain -> 0x00..0x0F in order, checking pointer wrap. Next: full FIFO with simultaneous rx_valid(0xBB)+rd_ack -> count stays 16, overrun unchanged, 0xBB read last.
- Flow control: push to 11 -> rx_ready=1. 12th push -> rx_ready=0 after that edge. Pop down to 5 -> still 0. Pop to 4 -> rx_ready=1.
- 5 bytes buffered, rx_break held high for 20 cycles -> break_pulse high exactly 1 cycle, break_det=1, count=0 (FLUSH_ON_BREAK=1). With FLUSH_ON_BREAK=0 -> count stays 5.
- rx_framing_error rising edge in the same cycle as status_clr -> framing_err=1. A later status_clr alone -> all sticky flags 0.
- Push 3 bytes, assert rst asynchronously between edges -> count=0, rd_valid=0, rx_ready=1 and all flags 0 immediately. After release, first pushed byte 0x5A appears at rd_data.
